// File: rtl/axi_r_resp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : axi_r_resp_pkg                                                   |
// | Brief   : Shared response codes and FSM state type for axi_r_resp_gen.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package axi_r_resp_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/axi_r_resp_gen_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : generic_fifo                                                     |
// | Brief   : Registered-output circular FIFO holding buffered R beats.       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module generic_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         test_en_i,
    input  logic                         valid_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic                         grant_i,
    output logic                         valid_o,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push;
    logic                  pop;
    logic                  unused_test_en;

    assign unused_test_en = test_en_i;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        push     = valid_i && (count_q != CNT_W'(DEPTH));
        pop      = grant_i && (count_q != '0);
        if (push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/axi_r_resp_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : axi_r_resp_gen                                                   |
// | Brief   : AXI read responder: INCR bursts from a req/gnt memory port into |
// |           a credited R-beat buffer. Optional AXI_R_RESP_ERR_EN adds       |
// |           mem_err_i and SLVERR responses.                                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module axi_r_resp_gen
    import axi_r_resp_pkg::*;
#(
    parameter int ID_WIDTH     = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int USER_WIDTH   = 6,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  test_en_i,
    input  logic                  ar_valid_i,
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    input  logic [7:0]            ar_len_i,
    input  logic [ID_WIDTH-1:0]   ar_id_i,
    input  logic [USER_WIDTH-1:0] ar_user_i,
    output logic                  ar_ready_o,
    output logic                  r_valid_o,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic [1:0]            r_resp_o,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic [USER_WIDTH-1:0] r_user_o,
    output logic                  r_last_o,
    input  logic                  r_ready_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
`ifdef AXI_R_RESP_ERR_EN
    input  logic                  mem_err_i,
`endif
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int FIFO_W     = 3 + DATA_WIDTH + USER_WIDTH + ID_WIDTH;
    localparam int CNT_W      = $clog2(BUFFER_DEPTH + 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [USER_WIDTH-1:0]   user_q, user_d;
    logic [7:0]              issued_cnt_q, issued_cnt_d;
    logic                    inflight_q, inflight_d;
    logic                    pend_last_q, pend_last_d;
    logic                    credit;
    logic [1:0]              beat_resp;
    logic [CNT_W-1:0]        fifo_count;
    logic [FIFO_W-1:0]       fifo_wdata;
    logic [FIFO_W-1:0]       fifo_rdata;

    // Credit uses registered occupancy, so a same-cycle pop never frees a slot early.
    assign credit = (int'(fifo_count) + int'(inflight_q)) < BUFFER_DEPTH;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        id_d         = id_q;
        user_d       = user_q;
        issued_cnt_d = issued_cnt_q;
        pend_last_d  = pend_last_q;
        ar_ready_o   = 1'b0;
        mem_req_o    = 1'b0;
        case (state_q)
            IDLE: begin
                ar_ready_o = 1'b1;
                if (ar_valid_i) begin
                    addr_d       = ar_addr_i;
                    len_d        = ar_len_i;
                    id_d         = ar_id_i;
                    user_d       = ar_user_i;
                    issued_cnt_d = '0;
                    state_d      = BURST;
                end
            end
            BURST: begin
                mem_req_o = (issued_cnt_q <= len_q) && credit;
                if (mem_req_o && mem_gnt_i) begin
                    addr_d       = addr_q + ADDR_WIDTH'(STRB_WIDTH);
                    issued_cnt_d = issued_cnt_q + 8'd1;
                    pend_last_d  = (issued_cnt_q == len_q);
                    if (issued_cnt_q == len_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        inflight_d = mem_req_o && mem_gnt_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            id_q         <= '0;
            user_q       <= '0;
            issued_cnt_q <= '0;
            inflight_q   <= 1'b0;
            pend_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            id_q         <= id_d;
            user_q       <= user_d;
            issued_cnt_q <= issued_cnt_d;
            inflight_q   <= inflight_d;
            pend_last_q  <= pend_last_d;
        end
    end

    assign mem_addr_o = addr_q;

`ifdef AXI_R_RESP_ERR_EN
    assign beat_resp = mem_err_i ? RESP_SLVERR : RESP_OKAY;
`else
    assign beat_resp = RESP_OKAY;
`endif

    // id/user are still those of the granting burst when its data returns.
    assign fifo_wdata = {id_q, user_q, mem_rdata_i, beat_resp, pend_last_q};

    generic_fifo #(
        .DATA_WIDTH (FIFO_W),
        .DEPTH      (BUFFER_DEPTH)
    ) u_r_buffer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .test_en_i (test_en_i),
        .valid_i   (mem_rvalid_i),
        .data_i    (fifo_wdata),
        .grant_i   (r_ready_i),
        .valid_o   (r_valid_o),
        .data_o    (fifo_rdata),
        .count_o   (fifo_count)
    );

    assign {r_id_o, r_user_o, r_data_o, r_resp_o, r_last_o} = fifo_rdata;

endmodule
`default_nettype wire
